// File: rtl/axi_wr_xbar_rr_if.sv
// ---------------------------------------------------------------------------
// axi_wr_xbar_rr_if
//   Bundle of AXI3 write-path signals (AW, W, B) for an NM-master to NS-slave
//   write crossbar.
//   - "_M" signals face the upstream masters. Per-master payloads are packed
//     arrays, and master i sits at element i.
//   - "_S" signals face the downstream slaves. AW and W payloads are one
//     shared bus, each slave has its own VALID/READY bit, and B payloads are
//     per slave.
//   Modports:
//     slave  - the crossbar's view. It accepts master requests and drives
//              the slave side.
//     master - the environment's view (masters and slaves around the xbar).
// ---------------------------------------------------------------------------
interface axi_wr_xbar_rr_if #(
    parameter int NM     = 2,
    parameter int NS     = 2,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    localparam int MI_W   = (NM > 1) ? $clog2(NM) : 1;
    localparam int SID_W  = ID_W + MI_W;
    localparam int STRB_W = DATA_W / 8;

    // master side
    logic [NM-1:0][ID_W-1:0]   AWID_M;
    logic [NM-1:0][ADDR_W-1:0] AWADDR_M;
    logic [NM-1:0][LEN_W-1:0]  AWLEN_M;
    logic [NM-1:0][2:0]        AWSIZE_M;
    logic [NM-1:0][1:0]        AWBURST_M;
    logic [NM-1:0]             AWVALID_M;
    logic [NM-1:0]             AWREADY_M;
    logic [NM-1:0][DATA_W-1:0] WDATA_M;
    logic [NM-1:0][STRB_W-1:0] WSTRB_M;
    logic [NM-1:0]             WLAST_M;
    logic [NM-1:0]             WVALID_M;
    logic [NM-1:0]             WREADY_M;
    logic [ID_W-1:0]           BID_M;
    logic [1:0]                BRESP_M;
    logic [NM-1:0]             BVALID_M;
    logic [NM-1:0]             BREADY_M;

    // slave side
    logic [SID_W-1:0]          AWID_S;
    logic [ADDR_W-1:0]         AWADDR_S;
    logic [LEN_W-1:0]          AWLEN_S;
    logic [2:0]                AWSIZE_S;
    logic [1:0]                AWBURST_S;
    logic [NS-1:0]             AWVALID_S;
    logic [NS-1:0]             AWREADY_S;
    logic [DATA_W-1:0]         WDATA_S;
    logic [STRB_W-1:0]         WSTRB_S;
    logic                      WLAST_S;
    logic [NS-1:0]             WVALID_S;
    logic [NS-1:0]             WREADY_S;
    logic [NS-1:0][SID_W-1:0]  BID_S;
    logic [NS-1:0][1:0]        BRESP_S;
    logic [NS-1:0]             BVALID_S;
    logic [NS-1:0]             BREADY_S;

    modport slave (
        input  AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
        output AWREADY_M,
        input  WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
        output WREADY_M,
        output BID_M, BRESP_M, BVALID_M,
        input  BREADY_M,
        output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
        input  AWREADY_S,
        output WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
        input  WREADY_S,
        input  BID_S, BRESP_S, BVALID_S,
        output BREADY_S
    );

    modport master (
        output AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
        input  AWREADY_M,
        output WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
        input  WREADY_M,
        input  BID_M, BRESP_M, BVALID_M,
        output BREADY_M,
        input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
        output AWREADY_S,
        input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
        output WREADY_S,
        output BID_S, BRESP_S, BVALID_S,
        input  BREADY_S
    );
endinterface

// File: rtl/axi_wr_xbar_rr.sv
// ---------------------------------------------------------------------------
// axi_wr_xbar_rr
//   AXI3 write-path crossbar (AW/W/B) from NM masters to NS slaves.
//   - Only one write is in flight at a time.
//   - Masters are arbitrated round-robin with a rotating pointer.
//   - The target slave is taken from ADDR[SEL_LSB +: SEL_W].
//   - The master index is prepended to the slave-side AWID. The B response is
//     routed back using the latched master index.
//   Optional build macro AXI_WR_XBAR_DECERR_EN:
//     When defined, a slave index >= NS goes to an internal default slave.
//     That slave sinks all W beats and answers with a DECERR B response.
//     When undefined, the slave index wraps modulo NS.
//   Ports:
//     ACLK    - clock
//     ARESETn - asynchronous active-low reset
//     bus     - axi_wr_xbar_rr_if.slave (all master- and slave-side signals)
// ---------------------------------------------------------------------------
module axi_wr_xbar_rr #(
    parameter int NM      = 2,
    parameter int NS      = 2,
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 4,
    parameter int SEL_LSB = 16,
    parameter int SEL_W   = 2
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    axi_wr_xbar_rr_if.slave   bus
);
    localparam int MI_W = (NM > 1) ? $clog2(NM) : 1;
    localparam int SI_W = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

    state_t            state;
    logic [MI_W-1:0]   ptr;
    logic [MI_W-1:0]   m;
    logic [SI_W-1:0]   s;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [LEN_W-1:0]  awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
`ifdef AXI_WR_XBAR_DECERR_EN
    logic              miss;
`endif

    // ---------------- round-robin arbiter ----------------
    // The loop scans from the far end toward ptr, so the last hit found is
    // the requester nearest to ptr in rotating order.
    logic            gnt_vld;
    logic [MI_W-1:0] gnt;
    logic [MI_W-1:0] idx;
    int              sum;

    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = '0;
        sum     = 0;
        for (int k = NM - 1; k >= 0; k--) begin
            sum = int'(ptr) + k;
            if (sum >= NM) sum = sum - NM;
            idx = MI_W'(sum);
            if (bus.AWVALID_M[idx]) begin
                gnt_vld = 1'b1;
                gnt     = idx;
            end
        end
    end

    // ---------------- slave decode ----------------
    logic [SEL_W-1:0] sel;
    logic [SI_W-1:0]  dec_s;

    assign sel = bus.AWADDR_M[gnt][SEL_LSB +: SEL_W];

`ifdef AXI_WR_XBAR_DECERR_EN
    logic dec_miss;
    assign dec_miss = (int'(sel) >= NS);
    assign dec_s    = dec_miss ? '0 : SI_W'(int'(sel));
`else
    assign dec_s    = SI_W'(int'(sel) % NS);
`endif

    // ---------------- handshakes seen by the FSM ----------------
    logic w_hs, b_hs;
    assign w_hs = bus.WVALID_M[m] & bus.WREADY_M[m];
    assign b_hs = bus.BVALID_M[m] & bus.BREADY_M[m];

    // ---------------- transaction FSM ----------------
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state   <= IDLE;
            ptr     <= '0;
            m       <= '0;
            s       <= '0;
            awid    <= '0;
            awaddr  <= '0;
            awlen   <= '0;
            awsize  <= '0;
            awburst <= '0;
`ifdef AXI_WR_XBAR_DECERR_EN
            miss    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (gnt_vld) begin
                    m       <= gnt;
                    s       <= dec_s;
                    awid    <= bus.AWID_M[gnt];
                    awaddr  <= bus.AWADDR_M[gnt];
                    awlen   <= bus.AWLEN_M[gnt];
                    awsize  <= bus.AWSIZE_M[gnt];
                    awburst <= bus.AWBURST_M[gnt];
`ifdef AXI_WR_XBAR_DECERR_EN
                    // A decode miss has no slave AW, so the FSM goes
                    // straight to the data phase.
                    miss    <= dec_miss;
                    state   <= dec_miss ? W : AW;
`else
                    state   <= AW;
`endif
                end
                AW: if (bus.AWREADY_S[s]) state <= W;
                W:  if (w_hs && bus.WLAST_M[m]) state <= B;
                B:  if (b_hs) begin
                    state <= IDLE;
                    ptr   <= (int'(m) == NM - 1) ? '0 : m + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The AW payload comes from registers, so it stays stable while
    // AWVALID_S is held.
    assign bus.AWID_S    = {m, awid};
    assign bus.AWADDR_S  = awaddr;
    assign bus.AWLEN_S   = awlen;
    assign bus.AWSIZE_S  = awsize;
    assign bus.AWBURST_S = awburst;

    // ---------------- channel steering ----------------
    always_comb begin
        bus.AWREADY_M = '0;
        bus.AWVALID_S = '0;
        bus.WREADY_M  = '0;
        bus.WVALID_S  = '0;
        bus.WDATA_S   = '0;
        bus.WSTRB_S   = '0;
        bus.WLAST_S   = 1'b0;
        bus.BVALID_M  = '0;
        bus.BREADY_S  = '0;
        bus.BID_M     = '0;
        bus.BRESP_M   = '0;

        // Gating with ARESETn keeps AWREADY low while reset is asserted,
        // even though the state already reads IDLE.
        if (ARESETn && state == IDLE && gnt_vld) bus.AWREADY_M[gnt] = 1'b1;

        if (state == AW) bus.AWVALID_S[s] = 1'b1;

        if (state == W) begin
            bus.WDATA_S     = bus.WDATA_M[m];
            bus.WSTRB_S     = bus.WSTRB_M[m];
            bus.WLAST_S     = bus.WLAST_M[m];
            bus.WVALID_S[s] = bus.WVALID_M[m];
            bus.WREADY_M[m] = bus.WREADY_S[s];
        end

        if (state == B) begin
            bus.BVALID_M[m] = bus.BVALID_S[s];
            bus.BREADY_S[s] = bus.BREADY_M[m];
            bus.BID_M       = bus.BID_S[s][ID_W-1:0];
            bus.BRESP_M     = bus.BRESP_S[s];
        end

`ifdef AXI_WR_XBAR_DECERR_EN
        // The default slave sinks every beat and returns DECERR with the
        // master's own ID.
        if (miss) begin
            bus.WVALID_S = '0;
            bus.WDATA_S  = '0;
            bus.WSTRB_S  = '0;
            bus.WLAST_S  = 1'b0;
            bus.WREADY_M = '0;
            bus.BVALID_M = '0;
            bus.BREADY_S = '0;
            bus.BID_M    = '0;
            bus.BRESP_M  = '0;
            if (state == W) bus.WREADY_M[m] = 1'b1;
            if (state == B) begin
                bus.BVALID_M[m] = 1'b1;
                bus.BID_M       = awid;
                bus.BRESP_M     = 2'b11;
            end
        end
`endif
    end
endmodule

// File: tb/tb_axi_wr_xbar_rr.sv
`timescale 1ns/1ps
module tb_axi_wr_xbar_rr;
    localparam int NM = 2, NS = 2, ID_W = 4, ADDR_W = 32, DATA_W = 32, LEN_W = 4;
    localparam int SEL_LSB = 16, SEL_W = 2;
    localparam int MI_W = (NM > 1) ? $clog2(NM) : 1;
    localparam int STRB_W = DATA_W / 8;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    axi_wr_xbar_rr_if #(.NM(NM), .NS(NS), .ID_W(ID_W), .ADDR_W(ADDR_W),
                        .DATA_W(DATA_W), .LEN_W(LEN_W)) bus();

    axi_wr_xbar_rr #(.NM(NM), .NS(NS), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                     .LEN_W(LEN_W), .SEL_LSB(SEL_LSB), .SEL_W(SEL_W))
        dut (.ACLK(ACLK), .ARESETn(ARESETn), .bus(bus));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int rr_ptr = 0;

    function automatic int ref_grant(input int mask, input int p);
        for (int k = 0; k < NM; k++) begin
            int i;
            i = (p + k) % NM;
            if (((mask >> i) & 1) == 1) return i;
        end
        return -1;
    endfunction

    // Returns the target slave; a value >= NS means a decode miss.
    function automatic int ref_slave(input logic [ADDR_W-1:0] a);
        int sel;
        sel = int'((a >> SEL_LSB) & ((32'd1 << SEL_W) - 1));
`ifdef AXI_WR_XBAR_DECERR_EN
        return sel;
`else
        return sel % NS;
`endif
    endfunction

    logic [ID_W-1:0]   t_id   [NM];
    logic [ADDR_W-1:0] t_addr [NM];
    logic [LEN_W-1:0]  t_len  [NM];
    logic [2:0]        t_size [NM];
    int                obs_g;

    task automatic idle_inputs();
        bus.AWID_M = '0; bus.AWADDR_M = '0; bus.AWLEN_M = '0; bus.AWSIZE_M = '0;
        bus.AWBURST_M = '0; bus.AWVALID_M = '0;
        bus.WDATA_M = '0; bus.WSTRB_M = '0; bus.WLAST_M = '0; bus.WVALID_M = '0;
        bus.BREADY_M = '0;
        bus.AWREADY_S = '0; bus.WREADY_S = '0;
        bus.BID_S = '0; bus.BRESP_S = '0; bus.BVALID_S = '0;
    endtask

    task automatic rand_payload();
        for (int i = 0; i < NM; i++) begin
            t_id[i]   = ID_W'($urandom);
            t_addr[i] = ADDR_W'($urandom);
            t_len[i]  = LEN_W'($urandom_range(0, 5));
            t_size[i] = 3'($urandom_range(0, 2));
        end
    endtask

    // One full write. aw_stall = cycles AWREADY_S is held low.
    // abort_beat >= 0 pulses reset while that W beat is offered.
    task automatic run_txn(input int mask, input int aw_stall, input int abort_beat);
        int g, es, nb, cyc;
        bit miss, hs, exp_wr, exp_bv;
        logic [DATA_W-1:0] wd;
        logic [STRB_W-1:0] ws;
        logic [63:0] exp_id, exp_resp;

        for (int i = 0; i < NM; i++) begin
            bus.AWID_M[i] = t_id[i];
            bus.AWADDR_M[i] = t_addr[i];
            bus.AWLEN_M[i] = t_len[i];
            bus.AWSIZE_M[i] = t_size[i];
            bus.AWBURST_M[i] = 2'b01;
        end
        bus.AWVALID_M = NM'(mask);
        g = ref_grant(mask, rr_ptr);
        es = ref_slave(t_addr[g]);
        miss = (es >= NS);

        @(negedge ACLK);
        obs_g = -1;
        for (int i = NM - 1; i >= 0; i--) if (bus.AWREADY_M[i]) obs_g = i;
        chk("awready_m_grant", 64'(bus.AWREADY_M), 64'(1) << g);
        chk("awvalid_s_idle", 64'(bus.AWVALID_S), 0);
        @(posedge ACLK); #1;

        // Requests and early W data presented while busy must be stalled.
        bus.AWVALID_M = NM'($urandom);
        bus.WVALID_M = '1;
        bus.WLAST_M = '1;

        if (!miss) begin
            for (int c = 0; c <= aw_stall; c++) begin
                bus.AWREADY_S = NS'($urandom) & ~(NS'(1) << es);
                if (c == aw_stall) bus.AWREADY_S[es] = 1'b1;
                @(negedge ACLK);
                chk("awvalid_s", 64'(bus.AWVALID_S), 64'(1) << es);
                chk("awid_s", 64'(bus.AWID_S), (64'(g) << ID_W) | 64'(t_id[g]));
                chk("awaddr_s", 64'(bus.AWADDR_S), 64'(t_addr[g]));
                chk("awlen_s", 64'(bus.AWLEN_S), 64'(t_len[g]));
                chk("awsize_s", 64'(bus.AWSIZE_S), 64'(t_size[g]));
                chk("wready_m_early", 64'(bus.WREADY_M), 0);
                chk("wvalid_s_early", 64'(bus.WVALID_S), 0);
                chk("awready_m_busy", 64'(bus.AWREADY_M), 0);
                @(posedge ACLK); #1;
            end
            bus.AWREADY_S = '0;
        end

        nb = int'(t_len[g]) + 1;
        for (int b = 0; b < nb; b++) begin
            wd = DATA_W'($urandom);
            ws = STRB_W'($urandom);
            cyc = 0;
            forever begin
                bus.WVALID_M = NM'($urandom);
                bus.WLAST_M = NM'($urandom);
                for (int i = 0; i < NM; i++) bus.WDATA_M[i] = DATA_W'($urandom);
                bus.WDATA_M[g] = wd;
                bus.WSTRB_M[g] = ws;
                bus.WLAST_M[g] = (b == nb - 1);
                bus.WVALID_M[g] = ($urandom_range(0, 3) != 0);
                bus.WREADY_S = NS'($urandom);
                bus.AWVALID_M = NM'($urandom);
                if (b == abort_beat) begin
                    bus.WVALID_M[g] = 1'b1;
                    bus.WREADY_S = '1;
                    bus.AWVALID_M = '1;
                    bus.BVALID_S = '1;
                    bus.BREADY_M = '1;
                    ARESETn = 1'b0;
                    @(negedge ACLK);
                    chk("rst_awready_m", 64'(bus.AWREADY_M), 0);
                    chk("rst_awvalid_s", 64'(bus.AWVALID_S), 0);
                    chk("rst_wready_m", 64'(bus.WREADY_M), 0);
                    chk("rst_wvalid_s", 64'(bus.WVALID_S), 0);
                    chk("rst_bvalid_m", 64'(bus.BVALID_M), 0);
                    chk("rst_bready_s", 64'(bus.BREADY_S), 0);
                    chk("rst_awid_s", 64'(bus.AWID_S), 0);
                    chk("rst_wdata_s", 64'(bus.WDATA_S), 0);
                    @(posedge ACLK); #1;
                    idle_inputs();
                    ARESETn = 1'b1;
                    rr_ptr = 0;
                    return;
                end
                @(negedge ACLK);
                exp_wr = miss ? 1'b1 : bus.WREADY_S[es];
                chk("wvalid_s", 64'(bus.WVALID_S),
                    (!miss && bus.WVALID_M[g]) ? (64'(1) << es) : 64'(0));
                chk("wready_m", 64'(bus.WREADY_M), exp_wr ? (64'(1) << g) : 64'(0));
                chk("awvalid_s_w", 64'(bus.AWVALID_S), 0);
                chk("awready_m_w", 64'(bus.AWREADY_M), 0);
                hs = bus.WVALID_M[g] && exp_wr;
                if (hs && !miss) begin
                    chk("wdata_s", 64'(bus.WDATA_S), 64'(wd));
                    chk("wstrb_s", 64'(bus.WSTRB_S), 64'(ws));
                    chk("wlast_s", 64'(bus.WLAST_S), 64'(b == nb - 1));
                end
                @(posedge ACLK); #1;
                if (hs) break;
                cyc++;
                if (cyc > 60) begin
                    chk("w_timeout", 64'(hs), 1);
                    break;
                end
            end
        end
        bus.WVALID_M = '0;

        cyc = 0;
        forever begin
            bus.AWVALID_M = NM'($urandom);
            bus.BVALID_S = NS'($urandom);
            for (int j = 0; j < NS; j++) begin
                bus.BID_S[j] = (ID_W + MI_W)'($urandom);
                bus.BRESP_S[j] = 2'($urandom);
            end
            // The real slave echoes the ID it received on AW.
            if (!miss) bus.BID_S[es] = (ID_W + MI_W)'((g << ID_W) | int'(t_id[g]));
            bus.BREADY_M = NM'($urandom);
            @(negedge ACLK);
            exp_bv = miss ? 1'b1 : bus.BVALID_S[es];
            exp_id = 64'(t_id[g]);
            exp_resp = miss ? 64'd3 : 64'(bus.BRESP_S[es]);
            chk("bvalid_m", 64'(bus.BVALID_M), exp_bv ? (64'(1) << g) : 64'(0));
            chk("bready_s", 64'(bus.BREADY_S),
                (!miss && bus.BREADY_M[g]) ? (64'(1) << es) : 64'(0));
            chk("awready_m_b", 64'(bus.AWREADY_M), 0);
            chk("wready_m_b", 64'(bus.WREADY_M), 0);
            if (exp_bv) begin
                chk("bid_m", 64'(bus.BID_M), exp_id);
                chk("bresp_m", 64'(bus.BRESP_M), exp_resp);
            end
            hs = exp_bv && bus.BREADY_M[g];
            @(posedge ACLK); #1;
            if (hs) break;
            cyc++;
            if (cyc > 60) begin
                chk("b_timeout", 64'(hs), 1);
                break;
            end
        end
        rr_ptr = (g + 1) % NM;
        idle_inputs();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        ARESETn = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        bus.AWVALID_M = '1; bus.WVALID_M = '1; bus.WREADY_S = '1;
        bus.AWREADY_S = '1; bus.BVALID_S = '1; bus.BREADY_M = '1;
        @(negedge ACLK);
        chk("reset_awready_m", 64'(bus.AWREADY_M), 0);
        chk("reset_awvalid_s", 64'(bus.AWVALID_S), 0);
        chk("reset_wready_m", 64'(bus.WREADY_M), 0);
        chk("reset_wvalid_s", 64'(bus.WVALID_S), 0);
        chk("reset_bvalid_m", 64'(bus.BVALID_M), 0);
        chk("reset_bready_s", 64'(bus.BREADY_S), 0);
        chk("reset_awid_s", 64'(bus.AWID_S), 0);
        chk("reset_awaddr_s", 64'(bus.AWADDR_S), 0);
        chk("reset_bid_m", 64'(bus.BID_M), 0);
        @(posedge ACLK); #1;
        idle_inputs();
        ARESETn = 1'b1;

        // M0 single write: slave 0, ID 3, four beats.
        rand_payload();
        t_id[0] = 4'h3; t_addr[0] = 32'h0000_0100; t_len[0] = 4'd3;
        run_txn(1, 0, -1);
        chk("first_grant", 64'(obs_g), 0);

        // Both masters request every time, so grants must alternate 1,0,1,0.
        for (int i = 0; i < 4; i++) begin
            rand_payload();
            run_txn(3, $urandom_range(0, 2), -1);
            chk("rr_alternate", 64'(obs_g), (i % 2 == 0) ? 64'd1 : 64'd0);
        end

        // M1 to slave 1, with AWREADY_S held low for five cycles.
        rand_payload();
        t_addr[1] = 32'h0001_0000; t_len[1] = 4'd2;
        run_txn(2, 5, -1);

        // Index 3 is a decode miss with DECERR enabled and slave 1 otherwise.
        rand_payload();
        t_addr[0] = 32'h0003_0000; t_len[0] = 4'd1;
        run_txn(1, 1, -1);

        // Reset during beat 2 of 4; the next grant must start from ptr 0.
        rand_payload();
        t_len[1] = 4'd3;
        run_txn(2, 0, 1);
        rand_payload();
        run_txn(3, 0, -1);
        chk("rr_after_reset", 64'(obs_g), 0);

        for (int n = 0; n < 30; n++) begin
            rand_payload();
            run_txn($urandom_range(1, (1 << NM) - 1), $urandom_range(0, 3), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_wr_xbar_rr.md
Name: axi_wr_xbar_rr

Overview:
- Parametrised write-path interconnect: NM AXI3 masters to NS AXI3 slaves, covering the AW, W and B channels.
- Successor to the fixed 2x2 write routing in the AXI top level.
- Round-robin arbitration with a rotating pointer, and address-based slave decode.
- One write transaction in flight at a time. Upstream master index is prepended to the slave-side ID; BID is routed back on it.

Parameters:
NM, 2, number of masters (2..8)
NS, 2, number of slaves (1..8)
ID_W, 4, master-side ID width; slave-side ID width is ID_W+MI_W, MI_W=$clog2(NM) (min 1)
ADDR_W, 32, address width
DATA_W, 32, data width; STRB_W=DATA_W/8
LEN_W, 4, AWLEN width
SEL_LSB, 16, lowest address bit of the slave-select field
SEL_W, 2, slave-select field width; slave index = ADDR[SEL_LSB+SEL_W-1:SEL_LSB]

Ports:
ACLK in 1 clock
ARESETn in 1 async active-low reset
AWID_M/AWADDR_M/AWLEN_M/AWSIZE_M/AWBURST_M in NM*{ID_W,ADDR_W,LEN_W,3,2} packed per-master AW payload, master i at slice i
AWVALID_M in NM, AWREADY_M out NM
WDATA_M/WSTRB_M/WLAST_M in NM*{DATA_W,STRB_W,1}
WVALID_M in NM, WREADY_M out NM
BID_M out ID_W (shared; qualified per master by BVALID_M)
BRESP_M out 2
BVALID_M out NM, BREADY_M in NM
AWID_S/AWADDR_S/AWLEN_S/AWSIZE_S/AWBURST_S out {ID_W+MI_W,ADDR_W,LEN_W,3,2} shared bus
AWVALID_S out NS, AWREADY_S in NS
WDATA_S/WSTRB_S/WLAST_S out {DATA_W,STRB_W,1} shared
WVALID_S out NS, WREADY_S in NS
BID_S/BRESP_S in NS*{ID_W+MI_W,2}
BVALID_S in NS, BREADY_S out NS

Behaviour:
- Clocking and reset: single clock ACLK; ARESETn asynchronous, active-low.
- Reset state: FSM in IDLE, rr pointer=0, latched master/slave/ID/payload=0. All VALID/READY outputs 0; all payload outputs 0.
- FSM states: IDLE -> AW -> W -> B -> IDLE.
- IDLE:
  - Grant is the first asserted AWVALID_M[i] searching i = ptr, ptr+1, ... mod NM.
  - AWREADY_M[grant]=1 combinationally, only in IDLE and only for the granted master.
  - On that handshake, register master index m, payload and decoded slave s; go to AW.
- AW:
  - AWVALID_S[s]=1 starting the cycle after acceptance (1-cycle latency); AWID_S={m,AWID}; payload held stable.
  - Hold until AWREADY_S[s]; then go to W.
- W:
  - Combinational pass-through: W*_S=W*_M[m]; WVALID_S[s]=WVALID_M[m]; WREADY_M[m]=WREADY_S[s].
  - All other WREADY_M and WVALID_S are 0.
  - Leave on the handshake with WLAST_M[m]=1. Beat count is not checked against AWLEN.
  - W beats presented during IDLE or AW are stalled (WREADY_M=0); no W-before-AW forwarding.
- B:
  - BREADY_S[s]=BREADY_M[m]; BVALID_M[m]=BVALID_S[s]; BID_M=BID_S[s][ID_W-1:0]; BRESP_M=BRESP_S[s].
  - On handshake: go to IDLE and set ptr=(m+1) mod NM.
  - BVALID_S from non-selected slaves is ignored (BREADY_S=0).
- Fairness: a master re-requesting immediately is placed last in priority; with all NM masters requesting, grants cycle 0,1,...,NM-1.
- Simultaneous events: a request arriving in the same cycle as the B handshake is not granted until the next IDLE cycle. Minimum turnaround is 1 idle cycle between transactions.
- AWVALID_M deasserted before grant: no grant, no state change.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs zeroed. No response is generated for the aborted transfer.
- Upper MI_W bits of BID_S are not checked; routing uses the latched m.

Optional Feature:
AXI_WR_XBAR_DECERR_EN
- Defined:
  - A slave index >= NS is a decode miss. The block skips AW and enters W with the internal default slave.
  - Default slave W: WREADY_M[m]=1 every cycle; data discarded; no WVALID_S asserted.
  - Default slave B: BVALID_M[m]=1, BRESP_M=2'b11 (DECERR), BID_M=latched AWID.
- Undefined:
  - Slave index = index mod NS. Every address maps to a real slave; the DECERR path is absent from RTL.

Test Plan:
- M0 AWADDR=0x0000_0100, AWID=4'h3, AWLEN=3, 4 W beats, slave-0 BRESP=0 -> AWVALID_S[0] asserts 1 cycle after AWREADY_M[0]; AWID_S=5'h03; 4 beats on slave 0; BID_M=4'h3, BVALID_M[0] only.
- M0 and M1 request continuously, NM=2 -> grants alternate 0,1,0,1; ptr=1 after first B handshake.
- M1 AWADDR=0x0001_0000 -> routed to slave 1, AWID_S[4]=1; AWREADY_S[1] held low 5 cycles -> AWVALID_S[1] and payload stable throughout; WREADY_M[1]=0 until AW handshake.
- DECERR_EN defined, AWADDR=0x0003_0000 (index 3, NS=2), AWLEN=1 -> 2 beats accepted with no WVALID_S; BRESP_M=2'b11; without the macro the same transfer goes to slave 1.
- ARESETn pulsed low during W beat 2 of 4 -> all VALID/READY outputs 0 that cycle; next grant restarts from ptr=0.
